// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - pipeline IF/MEM ports and byte-wide RAM port of mem_ctrl
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [31:0]       if_data;
  logic              if_done;
  logic              if_stall_req;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic              mem_stall_req;

  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  ram_din,
    output if_data, if_done, if_stall_req,
    output mem_rdata, mem_done, mem_stall_req,
    output ram_addr, ram_dout, ram_wr
  );

  modport master (
    output if_req, if_addr, if_flush,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output ram_din,
    input  if_data, if_done, if_stall_req,
    input  mem_rdata, mem_done, mem_stall_req,
    input  ram_addr, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM controller, MEM-over-IF arbitration, little-endian assembly
// Optional one-entry fetch buffer enabled by defining MEMCTRL_FETCH_BUF_EN.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              owner_if_q, owner_if_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [2:0]        mem_n;

`ifdef MEMCTRL_FETCH_BUF_EN
  logic              fb_valid_q, fb_valid_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [31:0]       fb_data_q, fb_data_d;
  logic              fb_hit, st_overlap;

  // Wrapping distance test: store range [mem_addr, +N) against buffered [fb_addr, +4).
  assign fb_hit     = fb_valid_q && (bus.if_addr == fb_addr_q);
  assign st_overlap = ((bus.mem_addr - fb_addr_q) < ADDR_W'(4)) ||
                      ((fb_addr_q - bus.mem_addr) < ADDR_W'(mem_n));
`endif

  always_comb begin
    case (bus.mem_size)
      2'd0:    mem_n = 3'd1;
      2'd1:    mem_n = 3'd2;
      default: mem_n = 3'd4;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    owner_if_d  = owner_if_q;
    cnt_d       = cnt_q;
    nbytes_d    = nbytes_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
`ifdef MEMCTRL_FETCH_BUF_EN
    fb_valid_d  = fb_valid_q;
    fb_addr_d   = fb_addr_q;
    fb_data_d   = fb_data_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.mem_req) begin
          owner_if_d = 1'b0;
          nbytes_d   = mem_n;
          cnt_d      = 3'd0;
          ram_addr_d = bus.mem_addr;
          rbuf_d     = '0;
          if (bus.mem_we) begin
            state_d    = S_WR;
            ram_wr_d   = 1'b1;
            ram_dout_d = bus.mem_wdata[7:0];
            wdata_d    = {8'h00, bus.mem_wdata[31:8]};
`ifdef MEMCTRL_FETCH_BUF_EN
            if (st_overlap) fb_valid_d = 1'b0;
`endif
          end else begin
            state_d = S_RD;
          end
        end else if (bus.if_req) begin
          owner_if_d = 1'b1;
`ifdef MEMCTRL_FETCH_BUF_EN
          if (fb_hit) begin
            state_d   = S_DONE;
            if_done_d = 1'b1;
            if_data_d = fb_data_q;
          end else
`endif
          begin
            state_d    = S_RD;
            nbytes_d   = 3'd4;
            cnt_d      = 3'd0;
            ram_addr_d = bus.if_addr;
            rbuf_d     = '0;
          end
        end
      end
      S_RD: begin
        if (owner_if_q && bus.if_flush) begin
          state_d = S_IDLE;
        end else begin
          // ram_din carries the byte addressed one cycle earlier, i.e. lane cnt-1.
          for (int i = 0; i < 4; i++) begin
            if (cnt_q == 3'(i + 1)) rbuf_d[8*i +: 8] = bus.ram_din;
          end
          if (cnt_q == nbytes_q) begin
            state_d = S_DONE;
            if (owner_if_q) begin
              if_done_d = 1'b1;
              if_data_d = rbuf_d;
`ifdef MEMCTRL_FETCH_BUF_EN
              fb_valid_d = 1'b1;
              fb_addr_d  = ram_addr_q - ADDR_W'(3);
              fb_data_d  = rbuf_d;
`endif
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = rbuf_d;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q + 3'd1 < nbytes_q) ram_addr_d = ram_addr_q + ADDR_W'(1);
          end
        end
      end
      S_WR: begin
        if (cnt_q + 3'd1 < nbytes_q) begin
          cnt_d      = cnt_q + 3'd1;
          ram_addr_d = ram_addr_q + ADDR_W'(1);
          ram_dout_d = wdata_q[7:0];
          wdata_d    = {8'h00, wdata_q[31:8]};
          ram_wr_d   = 1'b1;
        end else begin
          state_d    = S_DONE;
          mem_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_if_q  <= 1'b0;
      cnt_q       <= '0;
      nbytes_q    <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
`ifdef MEMCTRL_FETCH_BUF_EN
      fb_valid_q  <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_if_q  <= owner_if_d;
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
`ifdef MEMCTRL_FETCH_BUF_EN
      fb_valid_q  <= fb_valid_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
`endif
    end
  end

  assign bus.ram_addr      = ram_addr_q;
  assign bus.ram_dout      = ram_dout_q;
  assign bus.ram_wr        = ram_wr_q;
  assign bus.if_data       = if_data_q;
  assign bus.if_done       = if_done_q;
  assign bus.mem_rdata     = mem_rdata_q;
  assign bus.mem_done      = mem_done_q;
  assign bus.if_stall_req  = bus.if_req & ~if_done_q;
  assign bus.mem_stall_req = bus.mem_req & ~mem_done_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl against a byte-array reference model
module tb_mem_ctrl;
  localparam int ADDR_W = 32;
`ifdef MEMCTRL_FETCH_BUF_EN
  localparam bit FB_EN = 1'b1;
`else
  localparam bit FB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
  mem_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst_n), .bus(bus));

  typedef struct { logic [31:0] data; int cyc; bit chk; } exp_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; int cyc; } wr_t;

  exp_t if_q[$];
  exp_t mem_q[$];
  wr_t  wr_q[$];
  logic [7:0] ram [0:4095];
  logic [7:0] ref_mem [0:4095];
  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] last_if;
  bit fb_v;
  logic [31:0] fb_a;

  always @(posedge clk) begin
    if (bus.ram_wr) ram[bus.ram_addr[11:0]] <= bus.ram_dout;
    bus.ram_din <= ram[bus.ram_addr[11:0]];
    cyc <= cyc + 1;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void flag(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event occurred/absent contrary to model", name);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] d = '0;
    logic [31:0] p;
    for (int k = 0; k < n; k++) begin
      p = a + k;
      d[8*k +: 8] = ref_mem[p[11:0]];
    end
    return d;
  endfunction

  function automatic void ref_write(input logic [31:0] a, input int n, input logic [31:0] wd, input int c);
    logic [31:0] p;
    wr_t w;
    for (int k = 0; k < n; k++) begin
      p = a + k;
      ref_mem[p[11:0]] = wd[8*k +: 8];
      w.addr = p; w.data = wd[8*k +: 8]; w.cyc = c + 1 + k;
      wr_q.push_back(w);
    end
    if (fb_v && (((a - fb_a) < 32'd4) || ((fb_a - a) < 32'(n)))) fb_v = 1'b0;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return FB_EN && fb_v && (fb_a == a);
  endfunction

  function automatic void push_exp(input bit is_if, input logic [31:0] d, input int c, input bit chk);
    exp_t x;
    x.data = d; x.cyc = c; x.chk = chk;
    if (is_if) if_q.push_back(x); else mem_q.push_back(x);
  endfunction

  exp_t me, ie;
  wr_t  we_;
  always @(negedge clk) begin
    if (rst_n) begin
      check("if_stall_req", 32'(bus.if_stall_req), 32'(bus.if_req & ~bus.if_done));
      check("mem_stall_req", 32'(bus.mem_stall_req), 32'(bus.mem_req & ~bus.mem_done));
      if (bus.mem_done) begin
        if (mem_q.size() == 0) flag("mem_done_unexpected");
        else begin
          me = mem_q.pop_front();
          check("mem_done_cycle", 32'(cyc), 32'(me.cyc));
          if (me.chk) check("mem_rdata", bus.mem_rdata, me.data);
        end
      end
      if (bus.if_done) begin
        if (if_q.size() == 0) flag("if_done_unexpected");
        else begin
          ie = if_q.pop_front();
          check("if_done_cycle", 32'(cyc), 32'(ie.cyc));
          check("if_data", bus.if_data, ie.data);
        end
      end
      if (bus.ram_wr) begin
        if (wr_q.size() == 0) flag("ram_wr_unexpected");
        else begin
          we_ = wr_q.pop_front();
          check("ram_wr_addr", bus.ram_addr, we_.addr);
          check("ram_wr_data", 32'(bus.ram_dout), 32'(we_.data));
          check("ram_wr_cycle", 32'(cyc), 32'(we_.cyc));
        end
      end
    end
  end

  task automatic wait_done(input bit is_if, input string name);
    bit got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (is_if ? bus.if_done : bus.mem_done) got = 1'b1;
    end
    if (!got) flag(name);
    @(posedge clk); #1;
    if (is_if) bus.if_req = 1'b0; else bus.mem_req = 1'b0;
  endtask

  task automatic do_mem(input bit we, input logic [1:0] size, input logic [31:0] a,
                        input logic [31:0] wd, input bit drop);
    int n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    int e;
    @(posedge clk); #1;
    e = cyc;
    bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_size = size;
    bus.mem_addr = a; bus.mem_wdata = wd;
    if (we) begin
      ref_write(a, n, wd, e);
      push_exp(1'b0, 32'h0, e + n + 1, 1'b0);
    end else begin
      push_exp(1'b0, ref_read(a, n), e + n + 2, 1'b1);
    end
    if (drop) begin @(posedge clk); #1; bus.mem_req = 1'b0; end
    wait_done(1'b0, "mem_timeout");
  endtask

  task automatic do_fetch(input logic [31:0] a, input int flush_at, input bit drop);
    bit hit;
    int e;
    @(posedge clk); #1;
    e = cyc;
    hit = model_hit(a);
    bus.if_req = 1'b1; bus.if_addr = a;
    if (flush_at != 0 && !hit) begin
      repeat (flush_at) @(posedge clk);
      #1;
      bus.if_flush = 1'b1; bus.if_req = 1'b0;
      @(posedge clk); #1;
      bus.if_flush = 1'b0;
      @(negedge clk);
      check("if_data_after_flush", bus.if_data, last_if);
    end else begin
      last_if = ref_read(a, 4);
      push_exp(1'b1, last_if, hit ? e + 1 : e + 6, 1'b1);
      fb_v = 1'b1; fb_a = a;
      if (drop && !hit) begin @(posedge clk); #1; bus.if_req = 1'b0; end
      wait_done(1'b1, "if_timeout");
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    n_fail++;
    summary();
    $fatal(1);
  end

  int e;
  bit hit;
  logic [31:0] wd, a;
  logic [7:0] rv;
  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
    bus.mem_req = 0; bus.mem_we = 0; bus.mem_size = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
    for (int i = 0; i < 4096; i++) begin
      rv = 8'($urandom);
      ram[i] = rv; ref_mem[i] = rv;
    end
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    ref_mem[12'h100] = 8'h11; ref_mem[12'h101] = 8'h22; ref_mem[12'h102] = 8'h33; ref_mem[12'h103] = 8'h44;
    last_if = 0; fb_v = 0; fb_a = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_wr", 32'(bus.ram_wr), 0);
    check("rst_if_done", 32'(bus.if_done), 0);
    check("rst_mem_done", 32'(bus.mem_done), 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_ram_dout", 32'(bus.ram_dout), 0);
    check("rst_if_data", bus.if_data, 0);
    check("rst_mem_rdata", bus.mem_rdata, 0);
    rst_n = 1'b1;

    do_mem(1'b0, 2'd2, 32'h100, 32'h0, 1'b0);
    do_mem(1'b1, 2'd1, 32'h200, 32'hAABBCCDD, 1'b0);

    // Simultaneous requests: MEM byte load wins, fetch follows
    @(posedge clk); #1;
    e = cyc;
    bus.mem_req = 1; bus.mem_we = 0; bus.mem_size = 0; bus.mem_addr = 32'h300;
    bus.if_req = 1; bus.if_addr = 32'h104;
    push_exp(1'b0, ref_read(32'h300, 1), e + 3, 1'b1);
    hit = model_hit(32'h104);
    last_if = ref_read(32'h104, 4);
    push_exp(1'b1, last_if, hit ? e + 5 : e + 10, 1'b1);
    fb_v = 1; fb_a = 32'h104;
    wait_done(1'b0, "mem_timeout");
    wait_done(1'b1, "if_timeout");

    // Fetch of 0x0 flushed in c3, redirected to 0x8
    @(posedge clk); #1;
    e = cyc;
    bus.if_req = 1; bus.if_addr = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    bus.if_flush = 1; bus.if_addr = 32'h8;
    @(posedge clk); #1;
    bus.if_flush = 0;
    @(negedge clk);
    check("if_data_after_flush", bus.if_data, last_if);
    hit = model_hit(32'h8);
    last_if = ref_read(32'h8, 4);
    push_exp(1'b1, last_if, hit ? e + 5 : e + 10, 1'b1);
    fb_v = 1; fb_a = 32'h8;
    wait_done(1'b1, "if_timeout");

    // Reset in c2 of a word store: only byte 0 reaches the RAM
    @(posedge clk); #1;
    e = cyc;
    wd = $urandom;
    bus.mem_req = 1; bus.mem_we = 1; bus.mem_size = 2; bus.mem_addr = 32'h400; bus.mem_wdata = wd;
    ref_write(32'h400, 1, wd, e);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ram_wr", 32'(bus.ram_wr), 0);
    check("midrst_mem_done", 32'(bus.mem_done), 0);
    check("midrst_if_done", 32'(bus.if_done), 0);
    check("midrst_ram_addr", bus.ram_addr, 0);
    check("midrst_ram_dout", 32'(bus.ram_dout), 0);
    check("midrst_if_data", bus.if_data, 0);
    check("midrst_mem_rdata", bus.mem_rdata, 0);
    bus.mem_req = 0; fb_v = 0; last_if = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_mem(1'b0, 2'd2, 32'h400, 32'h0, 1'b0);

    // Fetch buffer sequence, store overlapping the buffered word
    do_fetch(32'h40, 0, 1'b0);
    do_fetch(32'h40, 0, 1'b0);
    do_mem(1'b1, 2'd0, 32'h42, $urandom, 1'b0);
    do_fetch(32'h40, 0, 1'b0);

    // Address wrap
    do_mem(1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0, 1'b0);
    do_fetch(32'hFFFF_FFFF, 0, 1'b0);
    do_mem(1'b1, 2'd3, 32'hFFFF_FFFD, $urandom, 1'b0);
    do_mem(1'b0, 2'd3, 32'hFFFF_FFFD, 32'h0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      int op;
      bit drop;
      op = int'($urandom_range(0, 2));
      drop = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF8 + $urandom_range(0, 7);
      else if ($urandom_range(0, 3) == 0) a = fb_a;
      else a = $urandom;
      case (op)
        0: do_fetch(a, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0, drop);
        1: do_mem(1'b0, 2'($urandom_range(0, 3)), a, 32'h0, drop);
        default: do_mem(1'b1, 2'($urandom_range(0, 3)), a, $urandom, drop);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    #1;
    check("if_q_left", 32'(if_q.size()), 0);
    check("mem_q_left", 32'(mem_q.size()), 0);
    check("wr_q_left", 32'(wr_q.size()), 0);
    summary();
    $finish;
  end
endmodule
